mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF stage) and load/store (MEM stage).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
//   XLEN            data/address width
//   MEM_BE_W        byte-enable width (one bit per byte of XLEN)
//   mem_arb_state_t arbiter FSM state encoding
//   mem_req_t       memory request payload (latched copy and m_* bundle)
package mem_port_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int MEM_BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT_I,
        ARB_WAIT_D
    } mem_arb_state_t;

    typedef struct packed {
        logic                we;
        logic [MEM_BE_W-1:0] be;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data requests win over fetch, except that after STARVE_LIMIT consecutive
// data wins against a pending fetch, fetch is forced through. Only one
// transaction is outstanding at a time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no transaction; arbitrate and latch the winner's payload
// ARB_REQ    | m_req high with stable payload, waiting for m_gnt
// ARB_WAIT_I | fetch accepted, waiting for m_rvalid (may be dropped)
// ARB_WAIT_D | data accepted, waiting for m_rvalid
//
// Ports
//   clk, reset                       clock, async active-low reset
//   i_req/i_addr/i_kill              fetch request, address, redirect kill
//   i_gnt/i_rvalid/i_rdata           fetch accept pulse, response pulse/data
//   d_req/d_we/d_be/d_addr/d_wdata   data request and payload
//   d_gnt/d_rvalid/d_rdata           data accept pulse, response pulse/data
//   m_req/m_we/m_be/m_addr/m_wdata   memory request and registered payload
//   m_gnt/m_rvalid/m_rdata           memory accept, response valid/data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [XLEN-1:0]     i_addr,
    input  logic                i_kill,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [XLEN-1:0]     i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [MEM_BE_W-1:0] d_be,
    input  logic [XLEN-1:0]     d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [XLEN-1:0]     d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [MEM_BE_W-1:0] m_be,
    output logic [XLEN-1:0]     m_addr,
    output logic [XLEN-1:0]     m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [XLEN-1:0]     m_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    mem_arb_state_t  state_q, state_d;
    mem_req_t        payload_q, payload_d;
    logic            owner_d_q, owner_d_d;     // 1: data owns the port
    logic [SW-1:0]   starve_q, starve_d;
    logic            drop_q, drop_d;
    logic            i_rvalid_q, i_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0] i_rdata_q, d_rdata_q;
    logic            data_wins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            payload_q  <= '0;
            owner_d_q  <= 1'b0;
            starve_q   <= '0;
            drop_q     <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            owner_d_q  <= owner_d_d;
            starve_q   <= starve_d;
            drop_q     <= drop_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            if (i_rvalid_d) i_rdata_q <= m_rdata;
            if (d_rvalid_d) d_rdata_q <= m_rdata;
        end
    end

    // Data wins unless fetch is pending and has already lost STARVE_LIMIT times.
    assign data_wins = d_req && !(i_req && (starve_q == STARVE_MAX));

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        owner_d_d  = owner_d_q;
        starve_d   = starve_q;
        drop_d     = drop_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!i_req) starve_d = '0;
                if (data_wins) begin
                    payload_d.we    = d_we;
                    payload_d.be    = d_be;
                    payload_d.addr  = d_addr;
                    payload_d.wdata = d_wdata;
                    owner_d_d       = 1'b1;
                    state_d         = ARB_REQ;
                    if (i_req && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
                end else if (i_req && !i_kill) begin
                    payload_d.we    = 1'b0;
                    payload_d.be    = '1;
                    payload_d.addr  = i_addr;
                    payload_d.wdata = '0;
                    owner_d_d       = 1'b0;
                    state_d         = ARB_REQ;
                    starve_d        = '0;
                end
            end
            ARB_REQ: begin
                if (m_gnt) begin
                    if (owner_d_q) begin
                        d_gnt   = 1'b1;
                        state_d = ARB_WAIT_D;
                    end else begin
                        i_gnt   = 1'b1;
                        state_d = ARB_WAIT_I;
                        // Redirect in the accept cycle: the response still arrives and must be eaten.
                        if (i_kill) drop_d = 1'b1;
                    end
                end else if (!owner_d_q && i_kill) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_I: begin
                if (m_rvalid) begin
                    state_d    = ARB_IDLE;
                    drop_d     = 1'b0;
                    i_rvalid_d = !drop_q && !i_kill;
                end else if (i_kill) begin
                    drop_d = 1'b1;
                end
            end
            ARB_WAIT_D: begin
                if (m_rvalid) begin
                    state_d    = ARB_IDLE;
                    d_rvalid_d = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign m_req    = (state_q == ARB_REQ);
    assign m_we     = payload_q.we;
    assign m_be     = payload_q.be;
    assign m_addr   = payload_q.addr;
    assign m_wdata  = payload_q.wdata;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    a_payload_stable: assert property (@(posedge clk) disable iff (!reset)
        (m_req && !m_gnt) |=> $stable(payload_q));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!reset)
        !(i_rvalid && d_rvalid));
    a_one_gnt: assert property (@(posedge clk) disable iff (!reset)
        !(i_gnt && d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays the memory side; every
// expected response is pushed to a scoreboard when m_rvalid is driven and
// popped when the arbiter pulses i_rvalid/d_rvalid.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_req, i_kill;
    logic [XLEN-1:0]     i_addr;
    logic                i_gnt, i_rvalid;
    logic [XLEN-1:0]     i_rdata;
    logic                d_req, d_we;
    logic [MEM_BE_W-1:0] d_be;
    logic [XLEN-1:0]     d_addr, d_wdata;
    logic                d_gnt, d_rvalid;
    logic [XLEN-1:0]     d_rdata;
    logic                m_req, m_we;
    logic [MEM_BE_W-1:0] m_be;
    logic [XLEN-1:0]     m_addr, m_wdata;
    logic                m_gnt, m_rvalid;
    logic [XLEN-1:0]     m_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_d; logic [XLEN-1:0] data; } sb_t;
    sb_t sb[$];

    int checks = 0;
    int errors = 0;
    int i_gnt_cnt = 0, d_gnt_cnt = 0, i_rv_cnt = 0, d_rv_cnt = 0;
    logic [XLEN-1:0]     seen_addr, seen_wdata;
    logic                seen_we;
    logic [MEM_BE_W-1:0] seen_be;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (i_gnt) i_gnt_cnt++;
            if (d_gnt) d_gnt_cnt++;
            if (i_rvalid) i_rv_cnt++;
            if (d_rvalid) d_rv_cnt++;
            if (i_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("rvalid_owner", {62'd0, i_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
                    check("rdata", e.is_d ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    // Grants the pending request, waits lat cycles, then returns data.
    // With kill_wait, i_kill is pulsed in WAIT_I and the response is expected to vanish.
    task automatic serve(input int lat, input logic [XLEN-1:0] data,
                         input logic exp_d, input logic kill_wait);
        for (int n = 0; n < 20 && !m_req; n++) tick();
        check("m_req_seen", m_req, 1'b1);
        if (!m_req) return;
        seen_addr  = m_addr;
        seen_we    = m_we;
        seen_be    = m_be;
        seen_wdata = m_wdata;
        m_gnt = 1'b1;
        #1;
        check("gnt_owner", {62'd0, i_gnt, d_gnt}, exp_d ? 64'd1 : 64'd2);
        tick();
        m_gnt = 1'b0;
        if (exp_d) d_req = 1'b0; else i_req = 1'b0;
        if (kill_wait) begin
            i_kill = 1'b1;
            tick();
            i_kill = 1'b0;
            repeat (lat - 2) tick();
        end else begin
            repeat (lat - 1) tick();
            sb.push_back('{is_d: exp_d, data: data});
        end
        m_rvalid = 1'b1;
        m_rdata  = data;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    initial begin
        int ig, dg, ir, dr;
        reset = 1'b0;
        i_req = 0; i_kill = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;

        // 1: reset, idle outputs
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("reset_outputs", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be}, 64'd0);
        check("reset_data", {i_rdata | d_rdata | m_wdata, m_addr}, 64'd0);
        check("reset_state", dut.state_q, ARB_IDLE);

        // 2: single fetch
        ig = i_gnt_cnt; ir = i_rv_cnt;
        i_req = 1; i_addr = 32'h100;
        serve(2, 32'h00A00093, 1'b0, 1'b0);
        tick();
        check("fetch_addr", seen_addr, 32'h100);
        check("fetch_we_be", {seen_we, seen_be}, 64'h0F);
        check("fetch_gnt_once", i_gnt_cnt - ig, 1);
        check("fetch_rvalid_once", i_rv_cnt - ir, 1);
        check("fetch_rdata_hold", i_rdata, 32'h00A00093);

        // 3: data beats fetch, then fetch
        dg = d_gnt_cnt; ig = i_gnt_cnt; dr = d_rv_cnt;
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D;
        serve(1, 32'h0, 1'b1, 1'b0);
        check("store_payload", {seen_we, seen_be, seen_addr}, {1'b1, 4'hF, 32'h2000});
        check("store_wdata", seen_wdata, 32'hCAFEF00D);
        serve(1, 32'h11111111, 1'b0, 1'b0);
        check("fetch_after_store_addr", seen_addr, 32'h104);
        tick();
        check("store_rvalid_once", d_rv_cnt - dr, 1);
        check("grant_counts", {d_gnt_cnt - dg, i_gnt_cnt - ig}, {32'd1, 32'd1});

        // 4: starvation guard (limit 2)
        i_req = 1; i_addr = 32'h108;
        d_we = 0; d_be = 4'h3;
        d_req = 1; d_addr = 32'h3000;
        serve(1, 32'hD0000001, 1'b1, 1'b0);
        check("starve_after_1", dut.starve_q, 1);
        d_req = 1; d_addr = 32'h3004;
        serve(2, 32'hD0000002, 1'b1, 1'b0);
        check("starve_after_2", dut.starve_q, 2);
        d_req = 1; d_addr = 32'h3008;
        serve(1, 32'h22222222, 1'b0, 1'b0);
        check("forced_fetch_addr", seen_addr, 32'h108);
        check("starve_cleared", dut.starve_q, 0);
        serve(1, 32'hD0000003, 1'b1, 1'b0);
        check("deferred_load_addr", seen_addr, 32'h3008);
        tick();

        // kill in REQ without grant: request withdrawn, no i_gnt
        ig = i_gnt_cnt;
        i_req = 1; i_addr = 32'h400;
        tick();
        check("kill_req_mreq", m_req, 1'b1);
        i_kill = 1; i_req = 0;
        tick();
        i_kill = 0;
        check("kill_req_withdrawn", {m_req, dut.state_q}, {1'b0, ARB_IDLE});
        check("kill_req_no_gnt", i_gnt_cnt - ig, 0);

        // 5: kill in WAIT_I drops the response; next fetch completes
        ir = i_rv_cnt;
        i_req = 1; i_addr = 32'h300;
        serve(3, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        check("killed_no_rvalid", i_rv_cnt - ir, 0);
        check("drop_cleared", dut.drop_q, 1'b0);
        i_req = 1; i_addr = 32'h200;
        serve(1, 32'h00000013, 1'b0, 1'b0);
        tick();
        check("refetch_addr", seen_addr, 32'h200);
        check("refetch_rvalid", i_rv_cnt - ir, 1);

        // 6: reset during WAIT_D, stale response afterwards
        dr = d_rv_cnt;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h5000; d_wdata = 32'h55;
        for (int n = 0; n < 20 && !m_req; n++) tick();
        check("wd_m_req", m_req, 1'b1);
        m_gnt = 1;
        tick();
        m_gnt = 0; d_req = 0;
        check("wd_state", dut.state_q, ARB_WAIT_D);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {m_req, m_we, m_be, d_rvalid, i_rvalid}, 64'd0);
        check("async_reset_payload", {m_addr, m_wdata}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
        tick();
        m_rvalid = 0; m_rdata = '0;
        tick();
        check("stale_no_rvalid", {d_rv_cnt - dr, 32'(d_rvalid)}, 64'd0);
        check("stale_rdata", d_rdata, 32'd0);
        check("stale_state", dut.state_q, ARB_IDLE);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "bench timeout");
    end

endmodule
